// File: rtl/addsub_result_stage.sv
// Result stage behind the N-bit adder/subtractor: it derives the flags and checks the sum,
// then buffers results in a 2-entry FIFO and keeps saturating op/overflow counters.
module addsub_result_stage #(
  parameter int unsigned N  = 3,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic          in_m,
  input  logic [N-1:0]  in_s,
  input  logic          in_c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_s,
  output logic          out_m,
  output logic          out_carry,
  output logic          out_borrow,
  output logic          out_zero,
  output logic          out_ovf,
  output logic [CW-1:0] op_count,
  output logic [CW-1:0] ovf_count,
  output logic          err
);

  typedef struct packed {
    logic [N-1:0] s;
    logic         m;
    logic         carry;
    logic         borrow;
    logic         zero;
    logic         ovf;
  } entry_t;

  entry_t          ent_q [0:1];
  entry_t          ent_d;
  logic            rptr_q, wptr_q;
  logic [1:0]      count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic [CW-1:0]   op_count_q, op_count_d;
  logic [CW-1:0]   ovf_count_q, ovf_count_d;
  logic            err_q, err_d;

  logic            push, pop;
  logic [N-1:0]    bm;
  logic [N:0]      ref_sum;
  logic            chk_fail;

  // Flag derivation and adder check on the incoming operation.
  always_comb begin
    bm        = in_b ^ {N{in_m}};
    ref_sum   = {1'b0, in_a} + {1'b0, bm} + {{N{1'b0}}, in_m};
    chk_fail  = ({in_c, in_s} != ref_sum);
    ent_d.s      = in_s;
    ent_d.m      = in_m;
    ent_d.carry  = in_c && !in_m;
    ent_d.borrow = !in_c && in_m;
    ent_d.zero   = (in_s == '0);
    ent_d.ovf    = (in_a[N-1] == bm[N-1]) && (in_s[N-1] != in_a[N-1]);
  end

  always_comb begin
    push = in_valid && in_ready_q;
    pop  = (count_q != 2'd0) && out_ready;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != 2'd2);

    op_count_d  = op_count_q;
    ovf_count_d = ovf_count_q;
    err_d       = err_q;
    if (push) begin
      if (op_count_q != '1) op_count_d = op_count_q + CW'(1);
      if (ent_d.ovf && (ovf_count_q != '1)) ovf_count_d = ovf_count_q + CW'(1);
      if (chk_fail) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) ent_q[i] <= '0;
      rptr_q      <= 1'b0;
      wptr_q      <= 1'b0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      op_count_q  <= '0;
      ovf_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (push) ent_q[wptr_q] <= ent_d;
      // 1-bit pointers wrap modulo 2 on their own.
      rptr_q      <= rptr_q ^ pop;
      wptr_q      <= wptr_q ^ push;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      op_count_q  <= op_count_d;
      ovf_count_q <= ovf_count_d;
      err_q       <= err_d;
    end
  end

  // Head entry straight from storage; the slot is not rewritten while it is the head.
  always_comb begin
    out_valid  = (count_q != 2'd0);
    out_s      = ent_q[rptr_q].s;
    out_m      = ent_q[rptr_q].m;
    out_carry  = ent_q[rptr_q].carry;
    out_borrow = ent_q[rptr_q].borrow;
    out_zero   = ent_q[rptr_q].zero;
    out_ovf    = ent_q[rptr_q].ovf;
  end

  assign in_ready  = in_ready_q;
  assign op_count  = op_count_q;
  assign ovf_count = ovf_count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_addsub_result_stage.sv
// Bench for addsub_result_stage: directed and randomized operations checked against an
// arithmetic reference model with a queue scoreboard; a CW=2 instance covers saturation.
module tb_addsub_result_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, in_m, in_c, out_valid, out_ready;
  logic [2:0] in_a, in_b, in_s, out_s;
  logic       out_m, out_carry, out_borrow, out_zero, out_ovf, err;
  logic [7:0] op_count, ovf_count;

  logic       in_valid2, in_ready2, in_m2, in_c2, out_valid2, out_ready2;
  logic [2:0] in_a2, in_b2, in_s2, out_s2;
  logic       out_m2, out_carry2, out_borrow2, out_zero2, out_ovf2, err2;
  logic [1:0] op_count2, ovf_count2;

  addsub_result_stage #(.N(3), .CW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_m(in_m), .in_s(in_s), .in_c(in_c), .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_m(out_m), .out_carry(out_carry), .out_borrow(out_borrow),
    .out_zero(out_zero), .out_ovf(out_ovf), .op_count(op_count), .ovf_count(ovf_count),
    .err(err)
  );

  addsub_result_stage #(.N(3), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2),
    .in_b(in_b2), .in_m(in_m2), .in_s(in_s2), .in_c(in_c2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_s(out_s2), .out_m(out_m2), .out_carry(out_carry2),
    .out_borrow(out_borrow2), .out_zero(out_zero2), .out_ovf(out_ovf2),
    .op_count(op_count2), .ovf_count(ovf_count2), .err(err2)
  );

  typedef struct packed {
    logic [2:0] s;
    logic       m;
    logic       carry;
    logic       borrow;
    logic       zero;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   exp_ops, exp_ovfs;
  bit   exp_err;
  int   checks, failures;

  // True adder behaviour: unsigned sum / difference, C3 = no-borrow in subtract mode.
  task automatic adder(input logic [2:0] a, b, input logic m,
                       output logic [2:0] s, output logic c);
    int full;
    full = m ? int'(a) + 8 - int'(b) : int'(a) + int'(b);
    c = (full >= 8);
    s = full[2:0];
  endtask

  function automatic exp_t model_entry(logic [2:0] a, b, logic m, logic [2:0] s, logic c);
    exp_t e;
    int sa, sb, r;
    sa = a[2] ? int'(a) - 8 : int'(a);
    sb = b[2] ? int'(b) - 8 : int'(b);
    r  = m ? sa - sb : sa + sb;
    e.s      = s;
    e.m      = m;
    e.carry  = c && !m;
    e.borrow = !c && m;
    e.zero   = (s == 3'd0);
    e.ovf    = (r > 3) || (r < -4);
    return e;
  endfunction

  // One clock: drive at negedge, update the model at the edge, return at the next negedge.
  task automatic cycle(input bit v, input logic [2:0] a, b, input logic m,
                       input logic [2:0] s, input logic c, input bit rdy);
    bit push, pop;
    logic [2:0] cs;
    logic cc;
    exp_t e;
    in_valid = v; in_a = a; in_b = b; in_m = m; in_s = s; in_c = c; out_ready = rdy;
    push = v && (q.size() < 2);
    pop  = rdy && (q.size() > 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      e = model_entry(a, b, m, s, c);
      q.push_back(e);
      if (exp_ops < 255) exp_ops++;
      if (e.ovf && exp_ovfs < 255) exp_ovfs++;
      adder(a, b, m, cs, cc);
      if ({cc, cs} !== {c, s}) exp_err = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; in_a = 'x; in_b = 'x; in_m = 'x; in_s = 'x; in_c = 'x;
  endtask

  task automatic rand_op(output logic [2:0] a, b, output logic m,
                         output logic [2:0] s, output logic c);
    a = 3'($urandom_range(0, 7));
    b = 3'($urandom_range(0, 7));
    m = 1'($urandom_range(0, 1));
    adder(a, b, m, s, c);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0;
    in_a2 = '0; in_b2 = '0; in_m2 = 1'b0; in_s2 = '0; in_c2 = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++;
    if ({out_s, out_m, out_carry, out_borrow, out_zero, out_ovf} !== 8'h00) begin
      failures++; $display("FAIL rst_outputs got=%h exp=00",
                           {out_s, out_m, out_carry, out_borrow, out_zero, out_ovf});
    end
    checks++;
    if ({op_count, ovf_count, err} !== 17'd0) begin
      failures++; $display("FAIL rst_counters got=%h/%h/%b exp=0", op_count, ovf_count, err);
    end
    @(negedge clk);
  endtask

  task automatic test_add;
    cycle(1'b1, 3'b101, 3'b011, 1'b0, 3'b000, 1'b1, 1'b1);
    checks++;
    if ({out_valid, out_carry, out_zero, out_ovf, out_borrow} !== 5'b11100) begin
      failures++; $display("FAIL add_flags got=%b exp=11100",
                           {out_valid, out_carry, out_zero, out_ovf, out_borrow});
    end
    checks++;
    if (op_count !== 8'd1) begin failures++; $display("FAIL add_op_count got=%0d exp=1", op_count); end
    cycle(1'b0, 'x, 'x, 'x, 'x, 'x, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sub;
    cycle(1'b1, 3'b101, 3'b011, 1'b1, 3'b010, 1'b1, 1'b1);
    checks++;
    if ({out_ovf, out_borrow, out_zero} !== 3'b100) begin
      failures++; $display("FAIL sub_ovf_flags got=%b exp=100", {out_ovf, out_borrow, out_zero});
    end
    checks++;
    if (ovf_count !== 8'd1) begin failures++; $display("FAIL sub_ovf_count got=%0d exp=1", ovf_count); end
    cycle(1'b1, 3'b011, 3'b101, 1'b1, 3'b110, 1'b0, 1'b1);
    checks++;
    if ({out_s, out_borrow, out_ovf} !== 5'b110_1_1) begin
      failures++; $display("FAIL sub_borrow_ovf got=%b exp=11011", {out_s, out_borrow, out_ovf});
    end
    cycle(1'b1, 3'b000, 3'b111, 1'b1, 3'b001, 1'b0, 1'b1);
    checks++;
    if ({out_s, out_borrow, out_ovf} !== 5'b001_1_0) begin
      failures++; $display("FAIL sub_borrow_only got=%b exp=00110", {out_s, out_borrow, out_ovf});
    end
    cycle(1'b0, 'x, 'x, 'x, 'x, 'x, 1'b1);
    checks++;
    if ({op_count, ovf_count} !== {8'd4, 8'd2}) begin
      failures++; $display("FAIL sub_counts got=%0d/%0d exp=4/2", op_count, ovf_count);
    end
  endtask

  task automatic test_back_pressure;
    logic [2:0] a[3], b[3], s[3];
    logic m[3], c[3];
    int base;
    base = exp_ops;
    for (int i = 0; i < 3; i++) rand_op(a[i], b[i], m[i], s[i], c[i]);
    cycle(1'b1, a[0], b[0], m[0], s[0], c[0], 1'b0);
    cycle(1'b1, a[1], b[1], m[1], s[1], c[1], 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, a[2], b[2], m[2], s[2], c[2], 1'b0);
      checks++;
      if ({in_ready, out_valid} !== 2'b01) begin
        failures++; $display("FAIL bp_stall got=%b exp=01", {in_ready, out_valid});
      end
      checks++;
      if ({out_s, out_m, out_carry, out_borrow, out_zero, out_ovf} !== q[0]) begin
        failures++; $display("FAIL bp_hold got=%h exp=%h",
                             {out_s, out_m, out_carry, out_borrow, out_zero, out_ovf}, q[0]);
      end
    end
    checks++;
    if (op_count !== 8'(base + 2)) begin
      failures++; $display("FAIL bp_count_before got=%0d exp=%0d", op_count, base + 2);
    end
    // Upstream keeps offering the third op until it is accepted during the drain.
    cycle(1'b1, a[2], b[2], m[2], s[2], c[2], 1'b1);
    cycle(1'b1, a[2], b[2], m[2], s[2], c[2], 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== (q.size() > 0)) begin
        failures++; $display("FAIL bp_drain_valid got=%b exp=%b", out_valid, q.size() > 0);
      end else if (q.size() > 0) begin
        checks++;
        if ({out_s, out_m, out_carry, out_borrow, out_zero, out_ovf} !== q[0]) begin
          failures++; $display("FAIL bp_drain_order got=%h exp=%h",
                               {out_s, out_m, out_carry, out_borrow, out_zero, out_ovf}, q[0]);
        end
      end
      cycle(1'b0, 'x, 'x, 'x, 'x, 'x, 1'b1);
    end
    checks++;
    if ({out_valid, op_count} !== {1'b0, 8'(base + 3)}) begin
      failures++; $display("FAIL bp_count_after got=%b/%0d exp=0/%0d", out_valid, op_count, base + 3);
    end
  endtask

  task automatic test_random;
    logic [2:0] a, b, s;
    logic m, c;
    for (int k = 0; k < 300; k++) begin
      rand_op(a, b, m, s, c);
      cycle(1'($urandom_range(0, 1)), a, b, m, s, c, ($urandom_range(0, 3) != 0));
      checks++;
      if ({out_valid, in_ready} !== {q.size() > 0, q.size() < 2}) begin
        failures++; $display("FAIL rnd_handshake got=%b exp=%b", {out_valid, in_ready},
                             {q.size() > 0, q.size() < 2});
      end
      if (q.size() > 0) begin
        checks++;
        if ({out_s, out_m, out_carry, out_borrow, out_zero, out_ovf} !== q[0]) begin
          failures++; $display("FAIL rnd_head got=%h exp=%h",
                               {out_s, out_m, out_carry, out_borrow, out_zero, out_ovf}, q[0]);
        end
      end
      checks++;
      if ({op_count, ovf_count, err} !== {8'(exp_ops), 8'(exp_ovfs), exp_err}) begin
        failures++; $display("FAIL rnd_status got=%0d/%0d/%b exp=%0d/%0d/%b",
                             op_count, ovf_count, err, exp_ops, exp_ovfs, exp_err);
      end
    end
  endtask

  task automatic test_corrupt;
    logic [2:0] a, b, s;
    logic m, c;
    cycle(1'b1, 3'b111, 3'b000, 1'b0, 3'b110, 1'b0, 1'b1);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL corrupt_err got=%b exp=1", err); end
    for (int k = 0; k < 6; k++) begin
      rand_op(a, b, m, s, c);
      cycle(1'b1, a, b, m, s, c, 1'b1);
    end
    checks++;
    if (err !== exp_err) begin failures++; $display("FAIL corrupt_sticky got=%b exp=%b", err, exp_err); end
  endtask

  task automatic test_async_reset;
    logic [2:0] a, b, s;
    logic m, c;
    for (int k = 0; k < 3; k++) begin
      rand_op(a, b, m, s, c);
      cycle(1'b1, a, b, m, s, c, 1'b0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, op_count, ovf_count, err} !== 18'd0) begin
      failures++; $display("FAIL arst_state got=%b/%0d/%0d/%b exp=0", out_valid, op_count,
                           ovf_count, err);
    end
    checks++;
    if ({out_s, out_m, out_carry, out_borrow, out_zero, out_ovf} !== 8'h00) begin
      failures++; $display("FAIL arst_flags got=%h exp=00",
                           {out_s, out_m, out_carry, out_borrow, out_zero, out_ovf});
    end
    q.delete(); exp_ops = 0; exp_ovfs = 0; exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++; $display("FAIL arst_release got=%b exp=10", {in_ready, out_valid});
    end
    @(negedge clk);
    rand_op(a, b, m, s, c);
    cycle(1'b1, a, b, m, s, c, 1'b0);
    checks++;
    if ({out_valid, op_count} !== {1'b1, 8'd1}) begin
      failures++; $display("FAIL arst_after_push got=%b/%0d exp=1/1", out_valid, op_count);
    end
  endtask

  task automatic test_saturation;
    out_ready2 = 1'b1;
    in_a2 = 3'b101; in_b2 = 3'b011; in_m2 = 1'b1; in_s2 = 3'b010; in_c2 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_valid2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({op_count2, ovf_count2} !== {2'(k > 3 ? 3 : k), 2'(k > 3 ? 3 : k)}) begin
        failures++; $display("FAIL sat_count k=%0d got=%0d/%0d exp=%0d", k, op_count2,
                             ovf_count2, k > 3 ? 3 : k);
      end
    end
    in_valid2 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    exp_ops = 0; exp_ovfs = 0; exp_err = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_back_pressure();
    test_random();
    test_corrupt();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_result_stage.md
Name: addsub_result_stage

Overview:
- Registered result stage directly downstream of the 3-bit adder_substractor.
- Takes one operation per handshake: operands A, B, mode M, and the adder's S, C3.
- Derives the status flags, checks the adder result against a reference sum, and buffers results in a 2-entry FIFO with valid/ready on both sides.
- Keeps saturating operation and overflow counters for the bench and for status readout.

Parameters:
- N, 3: operand/result width; must match the upstream adder.
- CW, 8: width of the op_count and ovf_count counters.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  stage can accept; registered; equals "FIFO not full".
- in_a  input  N  operand A.
- in_b  input  N  operand B, before the mode XOR.
- in_m  input  1  mode: 0 add, 1 subtract.
- in_s  input  N  adder sum S.
- in_c  input  1  adder carry-out C3.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes the head entry.
- out_s  output  N  stored S.
- out_m  output  1  stored mode.
- out_carry  output  1  unsigned carry; add mode only.
- out_borrow  output  1  unsigned borrow; subtract mode only.
- out_zero  output  1  S equals 0.
- out_ovf  output  1  signed two's-complement overflow.
- op_count  output  CW  operations accepted since reset; saturating.
- ovf_count  output  CW  accepted operations with ovf=1; saturating.
- err  output  1  sticky: an adder result failed the check.

Behaviour:
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- Flags are computed combinationally at push and stored with the entry:
  - Bm = in_b XOR {N{in_m}}.
  - carry = in_c && !in_m.
  - borrow = !in_c && in_m.
  - zero = (in_s == 0).
  - ovf = (in_a[N-1] == Bm[N-1]) && (in_s[N-1] != in_a[N-1]).
- Check: ref = in_a + Bm + in_m, computed at N+1 bits. If {in_c, in_s} != ref, err is set on the push edge. err clears only on rst.
- FIFO: 2 entries, storage registers, read pointer, write pointer, occupancy count 0..2. Outputs are driven from the head entry, registered.
- Latency: an operation pushed at edge k into an empty FIFO gives out_valid=1 after edge k; the head is visible in the following cycle. No combinational path from in_* to out_*.
- Occupancy transitions:
  - Empty: out_valid=0; a pop is impossible. Push moves to count 1.
  - Count 1, push and pop in the same cycle: count stays 1; the new entry becomes the head after the edge.
  - Count 1, push only: count 2; in_ready=0 in the following cycle.
  - Full (count 2): in_ready=0, so no push. A pop brings count to 1 and in_ready=1 in the next cycle.
- Pointers wrap modulo 2.
- While out_valid=1 and out_ready=0, all out_* are held stable.
- Counters: op_count += 1 per push; ovf_count += 1 per push with ovf=1. Both saturate at 2^CW-1 and never wrap.
- Reset (async, any time, including mid-transfer):
  - Pointers and count go to 0; the entry in flight is discarded.
  - out_valid=0, in_ready=1 after reset release.
  - out_s=0, out_m=0, out_carry=0, out_borrow=0, out_zero=0, out_ovf=0.
  - op_count=0, ovf_count=0, err=0.
- X on in_* while in_valid=0 must not affect state.

Test Plan:
- Add: A=101, B=011, M=0, S=000, C=1, out_ready=1 -> next cycle out_valid=1, out_carry=1, out_zero=1, out_ovf=0, out_borrow=0; op_count=1.
- Subtract overflow: A=101, B=011, M=1, S=010, C=1 -> out_ovf=1, out_borrow=0, out_zero=0; ovf_count=1.
- Subtract with borrow: A=011, B=101, M=1, S=110, C=0 -> out_borrow=1, out_ovf=1. Then A=000, B=111, M=1, S=001, C=0 -> out_borrow=1, out_ovf=0.
- Back-pressure: out_ready=0, push three ops back-to-back -> the third is stalled with in_ready=0 after two pushes; outputs stable. Raise out_ready -> entries drain in order, each exactly once; op_count=2 before the drain and 3 after.
- Corrupted adder: A=111, B=000, M=0, S=110, C=0 (correct result is 111, C=0) -> err=1 and stays 1 through later correct ops until rst.
- Async reset asserted mid-cycle with 2 entries held and counters non-zero -> immediately out_valid=0 and all counters/flags 0; after release in_ready=1. Saturation: CW=2, push 5 ops -> op_count holds at 3.
